// File: rtl/mult4_axi_lite_master_if.sv
// Job command/response port plus AXI4-Lite master channels of the mult4 job initiator.
// The master modport is the initiator's side; slave is the job source plus register slave.
interface mult4_axi_lite_master_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [3:0]  cmd_a;
   logic [3:0]  cmd_b;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [7:0]  rsp_result;
   logic        rsp_error;
   logic [31:0] AWADDR;
   logic [2:0]  AWPROT;
   logic        AWVALID;
   logic        AWREADY;
   logic [31:0] WDATA;
   logic [3:0]  WSTRB;
   logic        WVALID;
   logic        WREADY;
   logic [1:0]  BRESP;
   logic        BVALID;
   logic        BREADY;
   logic [31:0] ARADDR;
   logic [2:0]  ARPROT;
   logic        ARVALID;
   logic        ARREADY;
   logic [31:0] RDATA;
   logic [1:0]  RRESP;
   logic        RVALID;
   logic        RREADY;

   modport master (
      input  cmd_valid, cmd_a, cmd_b, rsp_ready,
      output cmd_ready, rsp_valid, rsp_result, rsp_error,
      output AWADDR, AWPROT, AWVALID, input AWREADY,
      output WDATA, WSTRB, WVALID, input WREADY,
      input  BRESP, BVALID, output BREADY,
      output ARADDR, ARPROT, ARVALID, input ARREADY,
      input  RDATA, RRESP, RVALID, output RREADY
   );

   modport slave (
      output cmd_valid, cmd_a, cmd_b, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_result, rsp_error,
      input  AWADDR, AWPROT, AWVALID, output AWREADY,
      input  WDATA, WSTRB, WVALID, output WREADY,
      output BRESP, BVALID, input BREADY,
      input  ARADDR, ARPROT, ARVALID, output ARREADY,
      output RDATA, RRESP, RVALID, input RREADY
   );
endinterface

// File: rtl/mult4_axi_lite_master.sv
// AXI4-Lite initiator running one multiply job on the memristor multiplier register slave:
// write operands, start, poll done, read result, clear start, then report on the rsp port.
module mult4_axi_lite_master #(
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
   parameter int          POLL_LIMIT = 16
) (
   input logic                     ACLK,
   input logic                     ARESETn,
   mult4_axi_lite_master_if.master bus
);
   localparam int PW = $clog2(POLL_LIMIT + 1);
   localparam logic [31:0] OFS_CONTROL = 32'h00;
   localparam logic [31:0] OFS_STATUS  = 32'h04;
   localparam logic [31:0] OFS_MPR     = 32'h08;
   localparam logic [31:0] OFS_MCD     = 32'h0C;
   localparam logic [31:0] OFS_RESULT  = 32'h10;

   typedef enum logic [2:0] {
      S_IDLE, S_WR_MPR, S_WR_MCD, S_WR_START, S_POLL, S_RD_RES, S_WR_CLR, S_RESP
   } state_t;

   state_t        r_state, w_nxt;
   logic          r_cmd_ready, r_rsp_valid, r_rsp_error;
   logic [7:0]    r_rsp_result;
   logic [3:0]    r_b;
   logic          r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;
   logic [31:0]   r_awaddr, r_wdata, r_araddr;
   logic [PW-1:0] r_poll_cnt;

   logic          w_cmd_fire, w_rsp_fire, w_b_fire, w_r_fire, w_bad, w_timeout;
   logic          w_launch, w_nxt_wr, w_nxt_rd;
   logic [PW-1:0] w_poll_inc;
   logic [31:0]   w_addr, w_wdata;

   always_comb begin
      w_cmd_fire = bus.cmd_valid && r_cmd_ready;
      w_rsp_fire = r_rsp_valid && bus.rsp_ready;
      w_b_fire   = r_bready && bus.BVALID;
      w_r_fire   = r_rready && bus.RVALID;
      w_bad      = (w_b_fire && (bus.BRESP != 2'b00)) || (w_r_fire && (bus.RRESP != 2'b00));
      w_poll_inc = r_poll_cnt + PW'(1);
      w_timeout  = 1'b0;
      w_nxt      = r_state;
      case (r_state)
         S_IDLE:     if (w_cmd_fire) w_nxt = S_WR_MPR;
         S_WR_MPR:   if (w_b_fire) w_nxt = w_bad ? S_WR_CLR : S_WR_MCD;
         S_WR_MCD:   if (w_b_fire) w_nxt = w_bad ? S_WR_CLR : S_WR_START;
         S_WR_START: if (w_b_fire) w_nxt = w_bad ? S_WR_CLR : S_POLL;
         S_POLL: if (w_r_fire) begin
            if (w_bad)                                 w_nxt = S_WR_CLR;
            else if (bus.RDATA[0])                     w_nxt = S_RD_RES;
            else if (w_poll_inc >= PW'(POLL_LIMIT)) begin
               w_nxt     = S_WR_CLR;
               w_timeout = 1'b1;
            end
         end
         S_RD_RES:   if (w_r_fire) w_nxt = S_WR_CLR;
         S_WR_CLR:   if (w_b_fire) w_nxt = S_RESP;
         S_RESP:     if (w_rsp_fire) w_nxt = S_IDLE;
         default:    w_nxt = S_IDLE;
      endcase
      // A new transfer is only ever issued on the edge that completes the previous one.
      w_launch = w_cmd_fire || w_b_fire || w_r_fire;
      w_nxt_wr = w_nxt inside {S_WR_MPR, S_WR_MCD, S_WR_START, S_WR_CLR};
      w_nxt_rd = w_nxt inside {S_POLL, S_RD_RES};
      case (w_nxt)
         S_WR_MPR: w_addr = BASE_ADDR + OFS_MPR;
         S_WR_MCD: w_addr = BASE_ADDR + OFS_MCD;
         S_POLL:   w_addr = BASE_ADDR + OFS_STATUS;
         S_RD_RES: w_addr = BASE_ADDR + OFS_RESULT;
         default:  w_addr = BASE_ADDR + OFS_CONTROL;
      endcase
      // The multiplier write launches on the accept edge, before r_ operands exist.
      case (w_nxt)
         S_WR_MPR:   w_wdata = {28'h0, bus.cmd_a};
         S_WR_MCD:   w_wdata = {28'h0, r_b};
         S_WR_START: w_wdata = 32'h1;
         default:    w_wdata = 32'h0;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         r_state      <= S_IDLE;
         r_cmd_ready  <= 1'b1;
         r_rsp_valid  <= 1'b0;
         r_rsp_error  <= 1'b0;
         r_rsp_result <= 8'h00;
         r_b          <= 4'h0;
         r_awvalid    <= 1'b0;
         r_wvalid     <= 1'b0;
         r_bready     <= 1'b0;
         r_arvalid    <= 1'b0;
         r_rready     <= 1'b0;
         r_awaddr     <= 32'h0;
         r_wdata      <= 32'h0;
         r_araddr     <= 32'h0;
         r_poll_cnt   <= '0;
      end else begin
         r_state <= w_nxt;
         if (w_cmd_fire) begin
            r_cmd_ready  <= 1'b0;
            r_b          <= bus.cmd_b;
            r_rsp_result <= 8'h00;
         end
         if (r_awvalid && bus.AWREADY) r_awvalid <= 1'b0;
         if (r_wvalid && bus.WREADY)   r_wvalid  <= 1'b0;
         if ((r_awvalid || r_wvalid) && !(r_awvalid && !bus.AWREADY) && !(r_wvalid && !bus.WREADY))
            r_bready <= 1'b1;
         if (w_b_fire) r_bready <= 1'b0;
         if (r_arvalid && bus.ARREADY) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
         end
         if (w_r_fire) r_rready <= 1'b0;
         if (w_launch && w_nxt_wr) begin
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
            r_awaddr  <= w_addr;
            r_wdata   <= w_wdata;
         end
         if (w_launch && w_nxt_rd) begin
            r_arvalid <= 1'b1;
            r_araddr  <= w_addr;
         end
         if (r_state == S_POLL && w_r_fire) r_poll_cnt <= w_poll_inc;
         if (r_state == S_RD_RES && w_r_fire && !w_bad) r_rsp_result <= bus.RDATA[7:0];
         // Error is sticky for the job and forces a zero result, even after a good RESULT read.
         if (w_bad || w_timeout) begin
            r_rsp_error  <= 1'b1;
            r_rsp_result <= 8'h00;
         end
         if (r_state == S_WR_CLR && w_b_fire) r_rsp_valid <= 1'b1;
         if (w_rsp_fire) begin
            r_rsp_valid <= 1'b0;
            r_rsp_error <= 1'b0;
            r_poll_cnt  <= '0;
            r_cmd_ready <= 1'b1;
         end
      end
   end

   assign bus.cmd_ready  = r_cmd_ready;
   assign bus.rsp_valid  = r_rsp_valid;
   assign bus.rsp_result = r_rsp_result;
   assign bus.rsp_error  = r_rsp_error;
   assign bus.AWADDR     = r_awaddr;
   assign bus.AWPROT     = 3'b000;
   assign bus.AWVALID    = r_awvalid;
   assign bus.WDATA      = r_wdata;
   assign bus.WSTRB      = 4'hF;
   assign bus.WVALID     = r_wvalid;
   assign bus.BREADY     = r_bready;
   assign bus.ARADDR     = r_araddr;
   assign bus.ARPROT     = 3'b000;
   assign bus.ARVALID    = r_arvalid;
   assign bus.RREADY     = r_rready;
endmodule

// File: tb/tb_mult4_axi_lite_master.sv
// Bench for mult4_axi_lite_master: reactive register-slave model, protocol monitor and
// a transaction-list reference model of one job, driven by directed and random jobs.
module tb_mult4_axi_lite_master;
   localparam logic [31:0] BASE   = 32'h4000_0000;
   localparam int          PL     = 4;
   localparam logic [31:0] A_CTRL = BASE;
   localparam logic [31:0] A_STAT = BASE + 32'h04;
   localparam logic [31:0] A_MPR  = BASE + 32'h08;
   localparam logic [31:0] A_MCD  = BASE + 32'h0C;
   localparam logic [31:0] A_RES  = BASE + 32'h10;
   localparam logic [31:0] A_NONE = 32'hFFFF_FFF0;

   typedef struct packed {logic wr; logic [31:0] addr; logic [31:0] data;} txn_t;

   logic ACLK = 1'b0;
   logic ARESETn = 1'b0;
   always #5 ACLK = ~ACLK;

   mult4_axi_lite_master_if bus();
   mult4_axi_lite_master #(.BASE_ADDR(BASE), .POLL_LIMIT(PL)) dut (
      .ACLK(ACLK), .ARESETn(ARESETn), .bus(bus));

   txn_t        log_q[$];
   txn_t        exp_q[$];
   int          checks = 0, errors = 0, viol = 0;
   int          aw_stall = 0, w_stall = 0, b_delay = 0, r_delay = 0, done_poll = 1;
   logic [31:0] err_addr = A_NONE;

   // Register slave model
   logic        aw_got, w_got, ar_got;
   logic [31:0] aw_a, w_d, ar_a, mpr, mcd;
   int          aw_c, w_c, b_c, r_c, st_cnt;

   function automatic logic [7:0] mul4(input logic [3:0] x, input logic [3:0] y);
      logic signed [7:0] p;
      p = $signed(x) * $signed(y);
      return p;
   endfunction

   always @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         bus.AWREADY <= 1'b0; bus.WREADY <= 1'b0; bus.BVALID <= 1'b0; bus.BRESP <= 2'b00;
         bus.ARREADY <= 1'b0; bus.RVALID <= 1'b0; bus.RRESP <= 2'b00; bus.RDATA <= 32'h0;
         aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
         aw_c <= 0; w_c <= 0; b_c <= 0; r_c <= 0; st_cnt <= 0;
         mpr <= 32'h0; mcd <= 32'h0; aw_a <= 32'h0; w_d <= 32'h0; ar_a <= 32'h0;
      end else begin
         if (bus.AWVALID && bus.AWREADY) begin
            aw_got <= 1'b1; aw_a <= bus.AWADDR; bus.AWREADY <= 1'b0; aw_c <= 0;
         end else if (bus.AWVALID && !aw_got) begin
            if (aw_c >= aw_stall) bus.AWREADY <= 1'b1; else aw_c <= aw_c + 1;
         end
         if (bus.WVALID && bus.WREADY) begin
            w_got <= 1'b1; w_d <= bus.WDATA; bus.WREADY <= 1'b0; w_c <= 0;
         end else if (bus.WVALID && !w_got) begin
            if (w_c >= w_stall) bus.WREADY <= 1'b1; else w_c <= w_c + 1;
         end
         if (bus.BVALID && bus.BREADY) begin
            bus.BVALID <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0; b_c <= 0;
         end else if (aw_got && w_got && !bus.BVALID) begin
            if (b_c >= b_delay) begin
               bus.BVALID <= 1'b1;
               bus.BRESP  <= (aw_a == err_addr) ? 2'b10 : 2'b00;
               log_q.push_back({1'b1, aw_a, w_d});
               if (aw_a == A_MPR) mpr <= w_d;
               if (aw_a == A_MCD) mcd <= w_d;
               if (aw_a == A_CTRL && w_d[0]) st_cnt <= 0;
            end else b_c <= b_c + 1;
         end
         if (bus.ARVALID && bus.ARREADY) begin
            ar_got <= 1'b1; ar_a <= bus.ARADDR; bus.ARREADY <= 1'b0;
         end else if (bus.ARVALID && !ar_got) bus.ARREADY <= 1'b1;
         if (bus.RVALID && bus.RREADY) begin
            bus.RVALID <= 1'b0; ar_got <= 1'b0; r_c <= 0;
         end else if (ar_got && !bus.RVALID) begin
            if (r_c >= r_delay) begin
               bus.RVALID <= 1'b1;
               bus.RRESP  <= (ar_a == err_addr) ? 2'b10 : 2'b00;
               log_q.push_back({1'b0, ar_a, 32'h0});
               if (ar_a == A_STAT) begin
                  bus.RDATA <= {16'hA5A4, 15'h1234, (done_poll != 0 && st_cnt + 1 == done_poll)};
                  st_cnt    <= st_cnt + 1;
               end else if (ar_a == A_RES) bus.RDATA <= {24'h7E5AC3, mul4(mpr[3:0], mcd[3:0])};
               else bus.RDATA <= 32'hDEAD_BEEF;
            end else r_c <= r_c + 1;
         end
      end
   end

   // Protocol monitor: pending requests stay stable, one transfer at a time, fixed PROT/STRB
   logic        p_awv, p_wv, p_arv;
   logic [31:0] p_awa, p_wd, p_ara;
   always @(posedge ACLK) begin
      if (!ARESETn) begin
         p_awv <= 1'b0; p_wv <= 1'b0; p_arv <= 1'b0;
      end else begin
         viol <= viol
            + int'(p_awv && (!bus.AWVALID || bus.AWADDR != p_awa))
            + int'(p_wv  && (!bus.WVALID  || bus.WDATA  != p_wd))
            + int'(p_arv && (!bus.ARVALID || bus.ARADDR != p_ara))
            + int'(bus.AWVALID && bus.AWREADY && (aw_got || bus.BVALID || ar_got || bus.RVALID))
            + int'(bus.WVALID && bus.WREADY && (w_got || bus.BVALID || ar_got || bus.RVALID))
            + int'(bus.ARVALID && bus.ARREADY && (ar_got || bus.RVALID || aw_got || w_got || bus.BVALID))
            + int'(bus.AWVALID && bus.AWPROT != 3'b000)
            + int'(bus.ARVALID && bus.ARPROT != 3'b000)
            + int'(bus.WVALID && bus.WSTRB != 4'hF);
         p_awv <= bus.AWVALID && !bus.AWREADY; p_awa <= bus.AWADDR;
         p_wv  <= bus.WVALID && !bus.WREADY;   p_wd  <= bus.WDATA;
         p_arv <= bus.ARVALID && !bus.ARREADY; p_ara <= bus.ARADDR;
      end
   end

   task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: the register transactions and response one job must produce
   task automatic model(input logic [3:0] a, input logic [3:0] b,
                        output logic [7:0] er, output logic ee);
      int p;
      exp_q.delete();
      er = 8'h00;
      exp_q.push_back({1'b1, A_MPR, {28'h0, a}});
      ee = (err_addr == A_MPR);
      if (!ee) begin exp_q.push_back({1'b1, A_MCD, {28'h0, b}}); ee = (err_addr == A_MCD); end
      if (!ee) begin exp_q.push_back({1'b1, A_CTRL, 32'h1}); ee = (err_addr == A_CTRL); end
      if (!ee) begin
         for (int k = 1; k <= PL; k++) begin
            exp_q.push_back({1'b0, A_STAT, 32'h0});
            if (err_addr == A_STAT) begin ee = 1'b1; break; end
            if (k == done_poll) break;
            if (k == PL) ee = 1'b1;
         end
      end
      if (!ee) begin
         exp_q.push_back({1'b0, A_RES, 32'h0});
         if (err_addr == A_RES) ee = 1'b1;
         else begin
            p  = int'($signed(a)) * int'($signed(b));
            er = p[7:0];
         end
      end
      exp_q.push_back({1'b1, A_CTRL, 32'h0});
      if (ee) er = 8'h00;
   endtask

   task automatic run_job(input string nm, input logic [3:0] a, input logic [3:0] b, input int hold);
      logic [7:0] er, r0;
      logic       ee, e0;
      int         n, v0, bad_rdy, unstable;
      model(a, b, er, ee);
      log_q.delete();
      v0 = viol;
      @(negedge ACLK);
      bus.cmd_a = a; bus.cmd_b = b; bus.cmd_valid = 1'b1;
      n = 0;
      while (!bus.cmd_ready && n < 100) begin @(negedge ACLK); n++; end
      chk({nm, " cmd_ready idle"}, 72'(bus.cmd_ready), 72'(1));
      @(negedge ACLK);
      bus.cmd_valid = 1'b0;
      bad_rdy = 0; n = 0;
      while (!bus.rsp_valid && n < 2000) begin
         bad_rdy += int'(bus.cmd_ready);
         @(negedge ACLK); n++;
      end
      chk({nm, " rsp_valid"}, 72'(bus.rsp_valid), 72'(1));
      chk({nm, " cmd_ready busy"}, 72'(bad_rdy), 72'(0));
      r0 = bus.rsp_result; e0 = bus.rsp_error; unstable = 0;
      repeat (hold) begin
         @(negedge ACLK);
         unstable += int'(bus.rsp_valid !== 1'b1 || bus.rsp_result !== r0 || bus.rsp_error !== e0);
      end
      chk({nm, " rsp hold"}, 72'(unstable), 72'(0));
      chk({nm, " rsp_result"}, 72'(r0), 72'(er));
      chk({nm, " rsp_error"}, 72'(e0), 72'(ee));
      bus.rsp_ready = 1'b1;
      @(negedge ACLK);
      bus.rsp_ready = 1'b0;
      chk({nm, " rsp_valid clr"}, 72'(bus.rsp_valid), 72'(0));
      chk({nm, " rsp_error clr"}, 72'(bus.rsp_error), 72'(0));
      chk({nm, " cmd_ready back"}, 72'(bus.cmd_ready), 72'(1));
      repeat (3) @(negedge ACLK);
      chk({nm, " txn count"}, 72'(log_q.size()), 72'(exp_q.size()));
      for (int i = 0; i < log_q.size() && i < exp_q.size(); i++)
         chk($sformatf("%s txn%0d", nm, i), 72'(log_q[i]), 72'(exp_q[i]));
      chk({nm, " protocol"}, 72'(viol - v0), 72'(0));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      bus.cmd_valid = 1'b0; bus.cmd_a = 4'h0; bus.cmd_b = 4'h0; bus.rsp_ready = 1'b0;
      repeat (3) @(negedge ACLK);
      chk("reset cmd_ready", 72'(bus.cmd_ready), 72'(1));
      chk("reset rsp", 72'({bus.rsp_valid, bus.rsp_error, bus.rsp_result}), 72'(0));
      chk("reset valids", 72'({bus.AWVALID, bus.WVALID, bus.BREADY, bus.ARVALID, bus.RREADY}), 72'(0));
      chk("reset addr/data", 72'({bus.AWADDR | bus.ARADDR | bus.WDATA}), 72'(0));
      ARESETn = 1'b1;

      done_poll = 1;
      run_job("basic", 4'h3, 4'h5, 0);
      done_poll = 4;
      run_job("poll4", 4'hD, 4'h5, 2);
      done_poll = 0;
      run_job("timeout", 4'h7, 4'h7, 0);
      done_poll = 1; err_addr = A_MCD;
      run_job("bresp_err", 4'h6, 4'h7, 0);
      err_addr = A_NONE;
      run_job("after_err", 4'h2, 4'hE, 0);
      aw_stall = 3; w_stall = 1; r_delay = 5; done_poll = 2;
      run_job("stall", 4'hF, 4'h8, 10);
      aw_stall = 0; w_stall = 0; r_delay = 0;

      // Reset while polling: everything drops at once, no response, next job unaffected
      done_poll = 0; r_delay = 2;
      @(negedge ACLK);
      bus.cmd_a = 4'h7; bus.cmd_b = 4'h2; bus.cmd_valid = 1'b1;
      @(negedge ACLK);
      bus.cmd_valid = 1'b0;
      n = 0;
      while (!(bus.ARVALID && bus.ARADDR == A_STAT) && n < 500) begin @(negedge ACLK); n++; end
      chk("reach poll", 72'(bus.ARADDR), 72'(A_STAT));
      ARESETn = 1'b0;
      #1;
      chk("mid reset valids", 72'({bus.AWVALID, bus.WVALID, bus.BREADY, bus.ARVALID, bus.RREADY}), 72'(0));
      chk("mid reset cmd/rsp", 72'({bus.cmd_ready, bus.rsp_valid}), 72'(2'b10));
      @(posedge ACLK); #1;
      chk("mid reset hold", 72'({bus.ARVALID, bus.RREADY, bus.rsp_valid, bus.cmd_ready}), 72'(4'b0001));
      repeat (2) @(negedge ACLK);
      ARESETn = 1'b1;
      r_delay = 0; done_poll = 1;
      run_job("post_reset", 4'h7, 4'h2, 0);

      for (int j = 0; j < 8; j++) begin
         logic [31:0] ea [5];
         ea[0] = A_NONE; ea[1] = A_MPR; ea[2] = A_STAT; ea[3] = A_RES; ea[4] = A_CTRL;
         err_addr  = ($urandom_range(0, 2) == 0) ? ea[$urandom_range(1, 4)] : A_NONE;
         done_poll = $urandom_range(0, PL + 1);
         aw_stall  = $urandom_range(0, 3); w_stall = $urandom_range(0, 3);
         b_delay   = $urandom_range(0, 2); r_delay = $urandom_range(0, 3);
         run_job($sformatf("rand%0d", j), 4'($urandom), 4'($urandom), $urandom_range(0, 3));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/mult4_axi_lite_master.md
Name: mult4_axi_lite_master

Overview:
- AXI4-Lite initiator that runs one complete 4-bit multiply job on the memristor multiplier peripheral's register slave.
- Accepts a job (two 4-bit operands) on a ready/valid command port.
- Runs the register sequence over the bus: write operands, pulse start, poll done, read result, clear start.
- Returns the 8-bit result, or an error flag, on a ready/valid response port.
- Sits between the on-chip job source (test sequencer or CPU-side FIFO) and the peripheral's AXI slave.

Parameters:
- BASE_ADDR, 32'h0000_0000, peripheral base; all register addresses are BASE_ADDR + offset.
- POLL_LIMIT, 16, maximum STATUS reads per job before declaring timeout (min 1).

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  job request
- cmd_ready  out  1  block idle, job accepted when cmd_valid&&cmd_ready
- cmd_a  in  4  multiplier operand
- cmd_b  in  4  multiplicand operand
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_result  out  8  RDATA[7:0] of RESULT read (signed product, passed unmodified)
- rsp_error  out  1  bus error (xRESP!=0) or poll timeout
- AWADDR out 32, AWPROT out 3, AWVALID out 1, AWREADY in 1  write address channel
- WDATA out 32, WSTRB out 4, WVALID out 1, WREADY in 1  write data channel
- BRESP in 2, BVALID in 1, BREADY out 1  write response channel
- ARADDR out 32, ARPROT out 3, ARVALID out 1, ARREADY in 1  read address channel
- RDATA in 32, RRESP in 2, RVALID in 1, RREADY out 1  read data channel

Behaviour:
- Reset values: all VALID outputs 0; cmd_ready 1; rsp_valid 0; rsp_result 0; rsp_error 0; BREADY/RREADY 0; AWADDR/ARADDR/WDATA 0; state IDLE; poll counter 0.
- Constants: AWPROT = ARPROT = 3'b000; WSTRB = 4'hF.
- Register map offsets: CONTROL 0x00 (bit0 start), STATUS 0x04 (bit0 done), MULTIPLIER 0x08, MULTIPLICAND 0x0C, RESULT 0x10.
- Job acceptance: operands are latched on cmd handshake; cmd_ready drops the next cycle and stays 0 until the response handshake completes.
- Main FSM: IDLE -> WR_MPR (0x08, {28'h0,a}) -> WR_MCD (0x0C, {28'h0,b}) -> WR_START (0x00, 32'h1) -> POLL (read 0x04) -> RD_RES (read 0x10) -> WR_CLR (0x00, 32'h0) -> RESP -> IDLE.
- Write sub-phase:
  - AWVALID and WVALID assert in the same cycle with address and data stable.
  - Each VALID drops independently in the cycle after its READY is sampled high.
  - BREADY then asserts; the phase ends on BVALID&&BREADY, and BREADY drops the following cycle.
  - No new request is issued before B completes.
- Read sub-phase:
  - ARVALID is held until ARREADY is sampled high.
  - RREADY then asserts; RDATA/RRESP are captured on RVALID&&RREADY.
- Outstanding transactions: at most one at a time, no overlap of reads and writes.
- POLL:
  - Each STATUS read increments the poll counter.
  - RDATA[0]=1 -> RD_RES.
  - RDATA[0]=0 with counter < POLL_LIMIT -> issue the next read the following cycle.
  - Counter reaches POLL_LIMIT with done still 0 -> set rsp_error, go to WR_CLR (skip RD_RES).
- Error: any BRESP or RRESP != 2'b00 sets sticky rsp_error for the job and jumps to WR_CLR. An error during WR_CLR itself -> RESP.
- RD_RES: rsp_result <= RDATA[7:0]. On error or timeout, rsp_result is 8'h00.
- RESP:
  - rsp_valid=1; rsp_result and rsp_error are held stable until rsp_ready.
  - Handshake clears rsp_valid and rsp_error, resets the poll counter, raises cmd_ready, and returns to IDLE.
- cmd_valid while busy is ignored (cmd_ready=0); no queueing.
- Latency with zero-wait slave: ~3 cycles per write, ~2 per read. Minimum job = 4 writes + k polls + 1 read.
- Asynchronous reset mid-transaction:
  - All VALIDs/READYs drop immediately and the job is discarded.
  - No response is issued; the peripheral must be reset by the same ARESETn.

Test Plan:
- BFM slave, zero wait, done on 1st poll; cmd a=3, b=5 -> AW sequence 0x08/0x3, 0x0C/0x5, 0x00/0x1, reads 0x04 then 0x10, final write 0x00/0x0; rsp_result=0x0F, rsp_error=0; cmd_ready low throughout.
- BFM done on 4th poll; a=4'hD, b=4'h5, BFM RESULT=0xF1 -> exactly four STATUS reads, rsp_result=0xF1, rsp_error=0.
- POLL_LIMIT=4, done never set -> exactly 4 STATUS reads, no RESULT read, CONTROL cleared to 0, rsp_error=1, rsp_result=0x00.
- BFM BRESP=2'b10 on MULTIPLICAND write -> no START write, CONTROL 0x00/0x0 write issued, rsp_error=1; the next job with good responses returns error=0.
- BFM stalls AWREADY 3 cycles and WREADY 1 cycle, RVALID delayed 5 cycles; rsp_ready held low 10 cycles -> VALIDs and addresses stay stable until handshake, no duplicate transfers, rsp_valid and rsp_result stable until rsp_ready.
- ARESETn asserted during POLL -> next cycle all VALID/READY outputs 0, cmd_ready=1, rsp_valid=0; a job after release completes normally.
